// File: rtl/uop_cache_ctrl_if.sv
// uop_cache_ctrl_if: fill/replay control inputs plus cache write/read port and status bundle.
interface uop_cache_ctrl_if #(parameter int AW = 6);
    logic          fill_valid;
    logic          fill_last;
    logic [31:0]   fill_instr;
    logic          replay_start;
    logic [7:0]    replay_iters;
    logic          stall;
    logic          flush;
    logic          cache_write_enable;
    logic [AW-1:0] cache_write_address;
    logic [31:0]   cache_instruction;
    logic          cache_read_enable;
    logic [AW-1:0] cache_read_address;
    logic          uop_valid;
    logic          replay_busy;
    logic          replay_done;
    logic          buf_valid;
    logic [AW:0]   buf_len;
    logic          fill_overflow;
    modport slave (
        input  fill_valid, fill_last, fill_instr, replay_start, replay_iters, stall, flush,
        output cache_write_enable, cache_write_address, cache_instruction,
               cache_read_enable, cache_read_address, uop_valid, replay_busy,
               replay_done, buf_valid, buf_len, fill_overflow
    );
    modport master (
        output fill_valid, fill_last, fill_instr, replay_start, replay_iters, stall, flush,
        input  cache_write_enable, cache_write_address, cache_instruction,
               cache_read_enable, cache_read_address, uop_valid, replay_busy,
               replay_done, buf_valid, buf_len, fill_overflow
    );
endinterface

// File: rtl/uop_cache_ctrl.sv
// uop_cache_ctrl: buffers a loop body into a uop cache and replays it a given number of times.
module uop_cache_ctrl #(parameter int AW = 6) (
    input logic           clk,
    input logic           reset,
    uop_cache_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FILL, OVF, REPLAY} state_t;
    localparam logic [AW-1:0] LAST_ADDR = '1;
    state_t        r_state, w_next;
    logic [AW-1:0] r_wptr, r_rptr;
    logic [7:0]    r_iters;
    logic [AW:0]   r_buf_len;
    logic          r_buf_valid, r_ovf, r_uop_valid, r_last, r_done;
    logic          w_fill, w_start, w_issue, w_wrap, w_final;
    assign w_fill  = bus.fill_valid & !bus.flush & !reset;
    assign w_start = (r_state == IDLE) & bus.replay_start & r_buf_valid &
                     (bus.replay_iters != 8'd0) & !bus.fill_valid & !bus.flush;
    assign w_issue = (r_state == REPLAY) & !bus.stall & !bus.flush & !reset;
    assign w_wrap  = {1'b0, r_rptr} == r_buf_len - (AW+1)'(1);
    assign w_final = w_issue & w_wrap & (r_iters == 8'd1);
    assign bus.cache_write_enable  = w_fill & ((r_state == IDLE) | (r_state == FILL));
    assign bus.cache_write_address = (r_state == IDLE) ? '0 : r_wptr;
    assign bus.cache_instruction   = bus.fill_instr;
    assign bus.cache_read_enable   = w_issue;
    assign bus.cache_read_address  = r_rptr;
    assign bus.uop_valid     = r_uop_valid;
    assign bus.replay_busy   = r_state == REPLAY;
    assign bus.replay_done   = r_done;
    assign bus.buf_valid     = r_buf_valid;
    assign bus.buf_len       = r_buf_len;
    assign bus.fill_overflow = r_ovf;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (w_fill & !bus.fill_last) ? FILL : w_start ? REPLAY : IDLE;
            FILL:    w_next = !w_fill ? FILL : bus.fill_last ? IDLE : (r_wptr == LAST_ADDR) ? OVF : FILL;
            OVF:     w_next = (w_fill & bus.fill_last) ? IDLE : OVF;
            default: w_next = w_final ? IDLE : REPLAY;
        endcase
        if (bus.flush) w_next = IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_iters     <= '0;
            r_buf_len   <= '0;
            r_buf_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_uop_valid <= 1'b0;
            r_last      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_fill & (r_state == IDLE)) begin
                r_buf_valid <= bus.fill_last;
                r_ovf       <= 1'b0;
                r_wptr      <= AW'(1);
                if (bus.fill_last) r_buf_len <= (AW+1)'(1);
            end else if (w_fill & (r_state == FILL)) begin
                if (bus.fill_last) begin
                    r_buf_valid <= 1'b1;
                    r_buf_len   <= {1'b0, r_wptr} + (AW+1)'(1);
                end else if (r_wptr == LAST_ADDR) r_ovf <= 1'b1;
                else r_wptr <= r_wptr + AW'(1);
            end
            if (bus.flush & ((r_state == FILL) | (r_state == OVF))) r_buf_valid <= 1'b0;
            if (w_start) begin
                r_rptr  <= '0;
                r_iters <= bus.replay_iters;
            end else if (w_issue) begin
                r_rptr <= w_wrap ? '0 : r_rptr + AW'(1);
                if (w_wrap) r_iters <= r_iters - 8'd1;
            end
            // a stalled uop keeps both its valid and its last marker until accepted
            r_uop_valid <= bus.flush ? 1'b0 : w_issue ? 1'b1 : bus.stall ? r_uop_valid : 1'b0;
            r_last      <= bus.flush ? 1'b0 : w_issue ? w_final : bus.stall ? r_last : 1'b0;
            r_done      <= !bus.flush & r_uop_valid & r_last & !bus.stall;
        end
    end
endmodule

// File: tb/tb_uop_cache_ctrl.sv
// tb_uop_cache_ctrl: directed and random fill/replay scenarios checked against a queue-based loop model.
module tb_uop_cache_ctrl;
    logic clk = 1'b0;
    logic reset;
    int total = 0, bad = 0;
    logic [31:0] mem [64];
    logic [31:0] rdata;
    logic [31:0] body [$];
    bit exp_valid, exp_ovf;
    uop_cache_ctrl_if #(.AW(6)) bus ();
    uop_cache_ctrl #(.AW(6)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (bus.cache_write_enable) mem[bus.cache_write_address] <= bus.cache_instruction;
        if (bus.cache_read_enable) rdata <= mem[bus.cache_read_address];
    end
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic do_fill(input int n, input bit last, input bit with_start);
        logic [31:0] q [$];
        logic [31:0] w;
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(3) == 0) begin
                bus.fill_valid = 1'b0;
                step();
            end
            w = $urandom;
            bus.fill_valid   = 1'b1;
            bus.fill_last    = last && (k == n - 1);
            bus.fill_instr   = w;
            bus.replay_start = with_start && (k == 0);
            bus.replay_iters = 8'd2;
            @(negedge clk);
            chk("busy_fill", bus.replay_busy, 0);
            if (k < 64) begin
                chk("wen", bus.cache_write_enable, 1);
                chk("waddr", bus.cache_write_address, k);
                chk("wdata", bus.cache_instruction, w);
                q.push_back(w);
            end else chk("wen_ovf", bus.cache_write_enable, 0);
            step();
        end
        bus.fill_valid   = 1'b0;
        bus.fill_last    = 1'b0;
        bus.replay_start = 1'b0;
        exp_valid = last && n <= 64;
        exp_ovf   = (n > 64) || (n == 64 && !last);
        if (exp_valid) body = q;
        @(negedge clk);
        chk("buf_valid", bus.buf_valid, exp_valid);
        chk("overflow", bus.fill_overflow, exp_ovf);
        chk("ren_fill", bus.cache_read_enable, 0);
        if (exp_valid) chk("buf_len", bus.buf_len, n);
        step();
    endtask
    task automatic do_replay(input int iters, input int pct, input int s_at, input int s_len);
        logic [31:0] exp_q [$];
        logic [31:0] hd;
        logic [5:0] ha;
        bit hp, hv, hb;
        int cyc;
        for (int i = 0; i < iters; i++)
            foreach (body[j]) exp_q.push_back(body[j]);
        bus.replay_start = 1'b1;
        bus.replay_iters = 8'(iters);
        step();
        bus.replay_start = 1'b0;
        cyc = 0;
        hp = 1'b0;
        while (exp_q.size() > 0 && cyc < 3000) begin
            bus.stall = (cyc >= s_at && cyc < s_at + s_len) || ($urandom_range(99) < pct);
            @(negedge clk);
            if (cyc == 0) chk("busy_start", bus.replay_busy, 1);
            if (hp) begin
                chk("hold_valid", bus.uop_valid, hv);
                if (hv) chk("hold_data", rdata, hd);
                if (hb) chk("hold_addr", bus.cache_read_address, ha);
            end
            chk("done_early", bus.replay_done, 0);
            if (bus.stall) chk("ren_stall", bus.cache_read_enable, 0);
            hp = bus.stall;
            hv = bus.uop_valid;
            hd = rdata;
            hb = bus.replay_busy;
            ha = bus.cache_read_address;
            if (bus.uop_valid && !bus.stall) chk("uop", rdata, exp_q.pop_front());
            step();
            cyc++;
        end
        bus.stall = 1'b0;
        chk("drain", exp_q.size(), 0);
        if (pct == 0 && s_len == 0) chk("rate", cyc, 1 + body.size() * iters);
        @(negedge clk);
        chk("done", bus.replay_done, 1);
        chk("busy_end", bus.replay_busy, 0);
        step();
        @(negedge clk);
        chk("done_pulse", bus.replay_done, 0);
        step();
    endtask
    task automatic try_start(input int iters);
        bus.replay_start = 1'b1;
        bus.replay_iters = 8'(iters);
        step();
        bus.replay_start = 1'b0;
        @(negedge clk);
        chk("ign_busy", bus.replay_busy, 0);
        chk("ign_ren", bus.cache_read_enable, 0);
        chk("ign_uop", bus.uop_valid, 0);
        step();
    endtask
    task automatic chk_reset_state(input string tag);
        chk({tag, "_uop"}, bus.uop_valid, 0);
        chk({tag, "_bufv"}, bus.buf_valid, 0);
        chk({tag, "_len"}, bus.buf_len, 0);
        chk({tag, "_ovf"}, bus.fill_overflow, 0);
        chk({tag, "_done"}, bus.replay_done, 0);
        chk({tag, "_busy"}, bus.replay_busy, 0);
        chk({tag, "_wen"}, bus.cache_write_enable, 0);
        chk({tag, "_ren"}, bus.cache_read_enable, 0);
    endtask
    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        body.delete();
        exp_valid = 1'b0;
        @(negedge clk);
        chk_reset_state("rst_mid");
        step();
    endtask
    initial begin
        reset = 1'b1;
        bus.fill_valid = 1'b0;
        bus.fill_last = 1'b0;
        bus.fill_instr = '0;
        bus.replay_start = 1'b0;
        bus.replay_iters = '0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_state("rst");
        step();
        reset = 1'b0;
        try_start(2);
        do_fill(3, 1'b1, 1'b0);
        do_replay(2, 0, 0, 0);
        do_replay(1, 0, 2, 2);
        try_start(0);
        do_fill(3, 1'b1, 1'b1);
        bus.replay_start = 1'b1;
        bus.replay_iters = 8'd3;
        step();
        bus.replay_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_ren", bus.cache_read_enable, 0);
        step();
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_uop", bus.uop_valid, 0);
        chk("flush_busy", bus.replay_busy, 0);
        chk("flush_bufv", bus.buf_valid, 1);
        chk("flush_len", bus.buf_len, 3);
        for (int i = 0; i < 3; i++) begin
            chk("flush_done", bus.replay_done, 0);
            step();
            @(negedge clk);
        end
        step();
        do_replay(1, 0, 0, 0);
        do_fill(64, 1'b1, 1'b0);
        do_replay(1, 20, 0, 0);
        do_fill(66, 1'b1, 1'b0);
        try_start(1);
        do_fill(2, 1'b1, 1'b0);
        for (int t = 0; t < 6; t++) begin
            do_fill($urandom_range(1, 12), 1'b1, 1'b0);
            do_replay($urandom_range(1, 4), 30, 0, 0);
        end
        do_fill(4, 1'b1, 1'b0);
        bus.replay_start = 1'b1;
        bus.replay_iters = 8'd2;
        step();
        bus.replay_start = 1'b0;
        repeat (2) step();
        pulse_reset();
        do_fill(5, 1'b0, 1'b0);
        pulse_reset();
        try_start(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
